// File: rtl/wide_reg_bank_pkg.sv
// Shared types and address helpers for the wide register bank.
// The address split assumes NWORDS is a power of two (1, 2 or 4).
package wide_reg_bank_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int aw_f(input int nregs, input int nwords);
    return (nregs * nwords > 1) ? $clog2(nregs * nwords) : 1;
  endfunction

  function automatic int reg_idx_f(input int unsigned addr, input int unsigned nwords);
    return int'(addr / nwords);
  endfunction

  function automatic int word_idx_f(input int unsigned addr, input int unsigned nwords);
    return int'(addr % nwords);
  endfunction

endpackage

// File: rtl/wide_reg_slot.sv
// Storage for one wide register: atomic load on commit plus a one-cycle strobe.
// Build option WIDE_REG_BANK_AUTOCLR_EN makes the value last only for the strobe cycle.
module wide_reg_slot
  import wide_reg_bank_pkg::*;
#(
  parameter int W = 2 * WORD_W
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         i_commit,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_strobe
);

  logic [W-1:0] r_data;
  logic         r_strobe;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_data   <= '0;
      r_strobe <= 1'b0;
    end else if (i_commit) begin
      r_data   <= i_data;
      r_strobe <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
`ifdef WIDE_REG_BANK_AUTOCLR_EN
      r_data   <= '0;
`endif
    end
  end

  assign o_data   = r_data;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/wide_reg_bank.sv
// NREGS wide registers of NWORDS 32-bit words on the VME word bus, with tear-free
// writes (shared write shadow) and reads (shared snapshot). Option: WIDE_REG_BANK_AUTOCLR_EN.
module wide_reg_bank
  import wide_reg_bank_pkg::*;
#(
  parameter int  NREGS  = 4,
  parameter int  NWORDS = 2,
  localparam int AW     = aw_f(NREGS, NWORDS)
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic [AW+1:2]                  VMEAddr,
  output logic [WORD_W-1:0]              VMERdData,
  input  logic [WORD_W-1:0]              VMEWrData,
  input  logic                           VMERdMem,
  input  logic                           VMEWrMem,
  output logic                           VMERdDone,
  output logic                           VMEWrDone,
  output logic [NREGS*NWORDS*WORD_W-1:0] regs_o,
  output logic [NREGS-1:0]               wr_strobe_o
);

  localparam int RW   = NWORDS * WORD_W;
  localparam int NTOT = NREGS * NWORDS;

  logic          r_wr_req_d0;
  logic [AW-1:0] r_wr_adr_d0;
  word_t         r_wr_dat_d0;
  logic          r_rd_done;
  word_t         r_rd_data;

  logic          w_wr_hit;
  int            w_wr_reg;
  int            w_wr_word;
  logic          w_rd_map;
  logic          w_rd_hit;
  int            w_rd_reg;
  int            w_rd_word;

  logic [NREGS*RW-1:0] w_regs;
  logic [RW-1:0]       w_commit_data;
  logic [RW-1:0]       w_rd_sel;
  logic [NREGS-1:0]    w_commit;
  word_t               w_rd_snap;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_req_d0 <= 1'b0;
      r_wr_adr_d0 <= '0;
      r_wr_dat_d0 <= '0;
    end else begin
      r_wr_req_d0 <= VMEWrMem;
      r_wr_adr_d0 <= VMEAddr;
      r_wr_dat_d0 <= VMEWrData;
    end
  end

  // Every write is acked; unmapped ones simply never reach a shadow or slot.
  assign VMEWrDone = r_wr_req_d0;
  assign w_wr_hit  = r_wr_req_d0 && (32'(r_wr_adr_d0) < NTOT);
  assign w_wr_reg  = reg_idx_f(32'(r_wr_adr_d0), NWORDS);
  assign w_wr_word = word_idx_f(32'(r_wr_adr_d0), NWORDS);

  assign w_rd_map  = 32'(VMEAddr) < NTOT;
  assign w_rd_hit  = VMERdMem && w_rd_map;
  assign w_rd_reg  = reg_idx_f(32'(VMEAddr), NWORDS);
  assign w_rd_word = word_idx_f(32'(VMEAddr), NWORDS);

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_rd_reg == i) w_rd_sel = w_regs[i*RW +: RW];
    end
  end

  assign w_commit_data[WORD_W-1:0] = r_wr_dat_d0;

  generate
    if (NWORDS > 1) begin : g_wide
      // Index k holds word k for the shadow, and word k+1 for the snapshot.
      word_t r_shadow [NWORDS-1];
      word_t r_snap   [NWORDS-1];

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int k = 0; k < NWORDS - 1; k++) begin
            r_shadow[k] <= '0;
            r_snap[k]   <= '0;
          end
        end else begin
          for (int k = 0; k < NWORDS - 1; k++) begin
            if (w_wr_hit && (w_wr_word == k)) r_shadow[k] <= r_wr_dat_d0;
            if (w_rd_hit && (w_rd_word == 0)) r_snap[k] <= w_rd_sel[(NWORDS-2-k)*WORD_W +: WORD_W];
          end
        end
      end

      for (genvar gi = 0; gi < NWORDS - 1; gi++) begin : g_word
        assign w_commit_data[(NWORDS-1-gi)*WORD_W +: WORD_W] = r_shadow[gi];
      end

      always_comb begin
        w_rd_snap = '0;
        for (int j = 1; j < NWORDS; j++) begin
          if (w_rd_word == j) w_rd_snap = r_snap[j-1];
        end
      end
    end else begin : g_narrow
      assign w_rd_snap = '0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_slot
      assign w_commit[gi] = w_wr_hit && (w_wr_reg == gi) && (w_wr_word == NWORDS - 1);

      wide_reg_slot #(
        .W (RW)
      ) u_slot (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_commit (w_commit[gi]),
        .i_data   (w_commit_data),
        .o_data   (w_regs[gi*RW +: RW]),
        .o_strobe (wr_strobe_o[gi])
      );
    end
  endgenerate

  // Word 0 is served live and freezes the rest; other words come from the freeze.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_done <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_done <= VMERdMem;
      if (VMERdMem) begin
        if (!w_rd_map)            r_rd_data <= '0;
        else if (w_rd_word == 0)  r_rd_data <= w_rd_sel[RW-1 -: WORD_W];
        else                      r_rd_data <= w_rd_snap;
      end
    end
  end

  assign VMERdDone = r_rd_done;
  assign VMERdData = r_rd_data;
  assign regs_o    = w_regs;

endmodule
